qr_col_packer: RTL
==================

# qr_col_packer

Upstream stage of the QR-CORDIC wrapper core. It consumes a 32-bit stream FIFO carrying two signed 16-bit matrix elements per word, saturates each element to 13 bits, and assembles four elements into one 52-bit column. Columns go into a small first-word-fall-through buffer that the core drains through the same empty_n/read handshake it uses on its input side. The block also tracks 8-column matrix framing, marks first and last columns, and flags framing errors and saturation events.

## Interface
- DATA_LENGTH, 13, element width after saturation
- ELEMS, 4, elements per column (fixed; column width DATA_LENGTH*ELEMS = 52)
- NUM_COL, 8, columns per matrix
- DEPTH, 2, column buffer depth (power of two, ≥2)
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- s_data  in  32  {elem_hi[31:16], elem_lo[15:0]}, signed two's complement; valid whenever s_empty_n=1
- s_last  in  1  upstream end-of-matrix marker, qualified with s_data
- s_empty_n  in  1  upstream FIFO has a word
- s_read  out  1  pop upstream word this cycle
- m_data  out  52  column {e3,e2,e1,e0}, e0 in [12:0]
- m_first  out  1  head column is column 0 of a matrix
- m_last  out  1  head column is the final column of a matrix
- m_empty_n  out  1  buffer holds ≥1 column
- m_read  in  1  consumer pops head column
- clr  in  1  synchronous clear of sticky flags
- err_early  out  1  sticky: s_last seen before word 2*NUM_COL-1
- err_late  out  1  sticky: word 2*NUM_COL-1 accepted without s_last
- sat_seen  out  1  sticky: any element saturated

## Operation
- Assembly FSM: LO (expect elements 0,1) → HI (expect elements 2,3) → LO. Transition only on accepted word (s_read=1).
- LO accept: store sat(s_data[15:0]) → e0, sat(s_data[31:16]) → e1.
- HI accept: push {sat(hi), sat(lo), e1, e0} into buffer with first/last tags.
- s_read = s_empty_n && (state==LO || count<DEPTH). Not dependent on m_read combinationally.
- Saturation: v>4095 → 4095; v<−4096 → −4096; else v[12:0]. Any clipped element sets sat_seen.
- Word counter wcnt, 0..2*NUM_COL−1. m_first tag = (column index 0); m_last tag = (wcnt==2*NUM_COL−1) or early last.
- Early last (s_last=1, wcnt<2*NUM_COL−1): set err_early; if in HI, push column tagged last; if in LO, discard the word and the half column; wcnt←0, state←LO.
- Late (wcnt==2*NUM_COL−1, s_last=0): column still tagged last, err_late set, wcnt←0. Counter is authoritative.
- Buffer: FWFT; m_data/m_first/m_last show head; pop when m_read && m_empty_n; m_read while empty ignored. Simultaneous push and pop keeps count.
- clr clears sticky flags; a same-cycle set event wins over clr.

## Timing
- Reset: state LO, wcnt 0, count 0, s_read 0 (follows s_empty_n combinationally), m_empty_n 0, m_data 0, m_first 0, m_last 0, all flags 0.
- Latency: HI word accepted at cycle t → column on m_data, m_empty_n=1 at t+1.
- Throughput: one word per cycle. Full rate is one column per 2 cycles.
- Buffer full while in HI: s_read held low until a pop frees an entry. The freed entry counts from the cycle after the pop.
- Reset mid-matrix discards the partial column, buffer contents, and framing state.

## Structure
- Shared package qr_pkg: DATA_LENGTH, NUM_COL, ELEMS, COL_W, and the LO/HI state encoding (also used by the core and the downstream unpacker).
- One sub-module: qr_col_fifo (FWFT, DEPTH×(COL_W+2), pointers and count). Saturation function is inline.

## Test plan
- Words 0x0002_0001, 0x0004_0003 with s_empty_n steady → one column, m_data e0..e3 = 1,2,3,4, m_first=1, m_last=0, at the cycle after the second read.
- Full matrix of 16 words, s_last on word 15, m_read=1 continuously → 8 columns, m_first only on col 0, m_last only on col 7, no error flags.
- Element 0x7FFF and 0x8000 → 0x0FFF and 0x1000 (−4096); sat_seen=1; clr pulse → 0.
- m_read=0 with 6 words offered → 2 columns buffered, s_read drops in HI on the 6th word; one m_read → that word accepted the next cycle.
- s_last on word 5 (LO word 2 of column 2 is word 4; word 5 is HI) → column 2 tagged last, err_early=1. Next word starts a new matrix with m_first=1.
- Word 15 without s_last → column 7 tagged last, err_late=1. rst_n low mid-matrix → m_empty_n=0 immediately, flags cleared.

Source files
------------

// File: rtl/qr_pkg.sv
// rtl/qr_pkg.sv - shared QR-CORDIC constants and column assembly state encoding
package qr_pkg;
  localparam int DATA_LENGTH = 13;
  localparam int ELEMS       = 4;
  localparam int NUM_COL     = 8;
  localparam int COL_W       = DATA_LENGTH * ELEMS;

  typedef enum logic {
    ST_LO = 1'b0,
    ST_HI = 1'b1
  } asm_state_e;
endpackage

// File: rtl/qr_col_packer_if.sv
// rtl/qr_col_packer_if.sv - upstream word FIFO and downstream column buffer handshakes
interface qr_col_packer_if;
  import qr_pkg::*;

  logic [31:0]    s_data;
  logic           s_last;
  logic           s_empty_n;
  logic           s_read;
  logic [COL_W-1:0] m_data;
  logic           m_first;
  logic           m_last;
  logic           m_empty_n;
  logic           m_read;

  modport slave (
    input  s_data, s_last, s_empty_n, m_read,
    output s_read, m_data, m_first, m_last, m_empty_n
  );

  modport master (
    output s_data, s_last, s_empty_n, m_read,
    input  s_read, m_data, m_first, m_last, m_empty_n
  );
endinterface

// File: rtl/qr_col_fifo.sv
// rtl/qr_col_fifo.sv - first-word-fall-through column buffer with occupancy count
module qr_col_fifo #(
  parameter int W     = 54,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         not_empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == CW'(DEPTH));
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && not_empty;
    do_push  = push && !full;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/qr_col_packer.sv
// rtl/qr_col_packer.sv - packs saturated 16-bit element pairs into tagged 52-bit columns
module qr_col_packer
  import qr_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  qr_col_packer_if.slave   bus,
  input  logic             clr,
  output logic             err_early,
  output logic             err_late,
  output logic             sat_seen
);
  localparam int WC_W = $clog2(2 * NUM_COL);
  localparam logic [WC_W-1:0] WMAX = WC_W'(2 * NUM_COL - 1);
  localparam logic signed [15:0] SAT_MAX = 16'((1 << (DATA_LENGTH - 1)) - 1);
  localparam logic signed [15:0] SAT_MIN = -SAT_MAX - 16'sd1;

  function automatic logic [DATA_LENGTH-1:0] sat(input logic signed [15:0] v);
    if (v > SAT_MAX) return SAT_MAX[DATA_LENGTH-1:0];
    if (v < SAT_MIN) return SAT_MIN[DATA_LENGTH-1:0];
    return v[DATA_LENGTH-1:0];
  endfunction

  function automatic logic clipped(input logic signed [15:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  asm_state_e             state_q, state_d;
  logic [WC_W-1:0]        wcnt_q, wcnt_d;
  logic [DATA_LENGTH-1:0] e0_q, e0_d, e1_q, e1_d;
  logic                   err_early_q, err_early_d;
  logic                   err_late_q, err_late_d;
  logic                   sat_seen_q, sat_seen_d;

  logic                   push, fifo_full, fifo_not_empty;
  logic [COL_W+1:0]       push_data, head;
  logic [DATA_LENGTH-1:0] lo_sat, hi_sat;
  logic                   at_end, early;

  assign lo_sat = sat(bus.s_data[15:0]);
  assign hi_sat = sat(bus.s_data[31:16]);
  assign at_end = (wcnt_q == WMAX);
  assign early  = bus.s_last && !at_end;

  // Only the HI word pushes, so LO words never wait on buffer space.
  assign bus.s_read = bus.s_empty_n && (state_q == ST_LO || !fifo_full);

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    e0_d        = e0_q;
    e1_d        = e1_q;
    err_early_d = clr ? 1'b0 : err_early_q;
    err_late_d  = clr ? 1'b0 : err_late_q;
    sat_seen_d  = clr ? 1'b0 : sat_seen_q;
    push        = 1'b0;
    push_data   = {1'b0, 1'b0, hi_sat, lo_sat, e1_q, e0_q};
    if (bus.s_read) begin
      if (clipped(bus.s_data[15:0]) || clipped(bus.s_data[31:16])) sat_seen_d = 1'b1;
      if (early) err_early_d = 1'b1;
      if (at_end && !bus.s_last) err_late_d = 1'b1;
      if (state_q == ST_LO) begin
        if (early) begin
          wcnt_d = '0;
        end else begin
          e0_d    = lo_sat;
          e1_d    = hi_sat;
          wcnt_d  = wcnt_q + WC_W'(1);
          state_d = ST_HI;
        end
      end else begin
        push      = 1'b1;
        push_data = {wcnt_q == WC_W'(1), at_end || early, hi_sat, lo_sat, e1_q, e0_q};
        wcnt_d    = (at_end || early) ? '0 : wcnt_q + WC_W'(1);
        state_d   = ST_LO;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LO;
      wcnt_q      <= '0;
      e0_q        <= '0;
      e1_q        <= '0;
      err_early_q <= 1'b0;
      err_late_q  <= 1'b0;
      sat_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      e0_q        <= e0_d;
      e1_q        <= e1_d;
      err_early_q <= err_early_d;
      err_late_q  <= err_late_d;
      sat_seen_q  <= sat_seen_d;
    end
  end

  qr_col_fifo #(
    .W     (COL_W + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (bus.m_read),
    .head      (head),
    .not_empty (fifo_not_empty),
    .full      (fifo_full)
  );

  assign bus.m_first   = head[COL_W+1];
  assign bus.m_last    = head[COL_W];
  assign bus.m_data    = head[COL_W-1:0];
  assign bus.m_empty_n = fifo_not_empty;
  assign err_early     = err_early_q;
  assign err_late      = err_late_q;
  assign sat_seen      = sat_seen_q;
endmodule
